// File: rtl/fp_addsub_seq.sv
// Multi-cycle floating-point adder/subtractor with an explicit align/add/normalise FSM.
// The larger operand is always placed in A, so subtraction of mantissas never goes negative.
module fp_addsub_seq #(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [MAN_W-1:0] man_a,
  input  logic [MAN_W-1:0] man_b,
  input  logic             sgn_a,
  input  logic             sgn_b,
  input  logic [EXP_W-1:0] exp_a,
  input  logic [EXP_W-1:0] exp_b,
  input  logic             op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [MAN_W-1:0] res_man,
  output logic             res_sgn,
  output logic [EXP_W:0]   res_exp,
  output logic             underflow,
  output logic             busy
);

  typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, DONE} state_t;

  state_t           state;
  logic [MAN_W-1:0] a_man, b_man;
  logic [EXP_W-1:0] a_exp, b_exp;
  logic             a_sgn, b_sgn, op_r, eff_sub;
  logic [MAN_W:0]   w_man;
  logic [EXP_W:0]   w_exp;

  logic             swap;
  logic             b_sgn_eff;
  logic [MAN_W-1:0] big_man, small_man, small_shifted;
  logic [EXP_W-1:0] big_exp, small_exp, exp_diff;
  logic             big_sgn, small_sgn;

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);

  // B's effective sign folds in the operation before ordering, so the swap carries it along.
  always_comb begin
    b_sgn_eff     = b_sgn ^ op_r;
    swap          = (b_exp > a_exp) || ((b_exp == a_exp) && (b_man > a_man));
    big_man       = swap ? b_man : a_man;
    big_exp       = swap ? b_exp : a_exp;
    big_sgn       = swap ? b_sgn_eff : a_sgn;
    small_man     = swap ? a_man : b_man;
    small_exp     = swap ? a_exp : b_exp;
    small_sgn     = swap ? a_sgn : b_sgn_eff;
    exp_diff      = big_exp - small_exp;
    small_shifted = (32'(exp_diff) >= 32'(MAN_W)) ? '0 : (small_man >> exp_diff);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      a_man     <= '0;
      b_man     <= '0;
      a_exp     <= '0;
      b_exp     <= '0;
      a_sgn     <= 1'b0;
      b_sgn     <= 1'b0;
      op_r      <= 1'b0;
      eff_sub   <= 1'b0;
      w_man     <= '0;
      w_exp     <= '0;
      out_valid <= 1'b0;
      res_man   <= '0;
      res_sgn   <= 1'b0;
      res_exp   <= '0;
      underflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_man <= man_a;
            b_man <= man_b;
            a_exp <= exp_a;
            b_exp <= exp_b;
            a_sgn <= sgn_a;
            b_sgn <= sgn_b;
            op_r  <= op;
            state <= ALIGN;
          end
        end
        ALIGN: begin
          a_man   <= big_man;
          a_exp   <= big_exp;
          a_sgn   <= big_sgn;
          b_man   <= small_shifted;
          eff_sub <= big_sgn ^ small_sgn;
          state   <= ADD;
        end
        ADD: begin
          w_man <= eff_sub ? ({1'b0, a_man} - {1'b0, b_man})
                           : ({1'b0, a_man} + {1'b0, b_man});
          w_exp <= {1'b0, a_exp};
          state <= NORM;
        end
        NORM: begin
          // Priority: carry-out, exact zero, already normalised, shift left, exponent floor.
          if (w_man[MAN_W]) begin
            res_man   <= w_man[MAN_W:1];
            res_exp   <= w_exp + 1'b1;
            res_sgn   <= a_sgn;
            underflow <= 1'b0;
            out_valid <= 1'b1;
            state     <= DONE;
          end else if (w_man == '0) begin
            res_man   <= '0;
            res_exp   <= '0;
            res_sgn   <= 1'b0;
            underflow <= 1'b0;
            out_valid <= 1'b1;
            state     <= DONE;
          end else if (w_man[MAN_W-1]) begin
            res_man   <= w_man[MAN_W-1:0];
            res_exp   <= w_exp;
            res_sgn   <= a_sgn;
            underflow <= 1'b0;
            out_valid <= 1'b1;
            state     <= DONE;
          end else if (w_exp != '0) begin
            w_man <= w_man << 1;
            w_exp <= w_exp - 1'b1;
          end else begin
            res_man   <= w_man[MAN_W-1:0];
            res_exp   <= '0;
            res_sgn   <= a_sgn;
            underflow <= 1'b1;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_addsub_seq.sv
// Randomised and directed bench for fp_addsub_seq against an arithmetic reference model.
// Covers latency, backpressure, ignored inputs while busy, and reset mid-operation.
module tb_fp_addsub_seq;

  localparam int EXP_W = 5;
  localparam int MAN_W = 10;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid, in_ready;
  logic [MAN_W-1:0] man_a, man_b;
  logic             sgn_a, sgn_b;
  logic [EXP_W-1:0] exp_a, exp_b;
  logic             op;
  logic             out_valid, out_ready;
  logic [MAN_W-1:0] res_man;
  logic             res_sgn;
  logic [EXP_W:0]   res_exp;
  logic             underflow, busy;

  int checks = 0;
  int errors = 0;

  fp_addsub_seq #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .man_a(man_a), .man_b(man_b), .sgn_a(sgn_a), .sgn_b(sgn_b),
    .exp_a(exp_a), .exp_b(exp_b), .op(op), .out_valid(out_valid),
    .out_ready(out_ready), .res_man(res_man), .res_sgn(res_sgn),
    .res_exp(res_exp), .underflow(underflow), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  // Value-level model: order by magnitude, align, add, then normalise by repeated doubling.
  function automatic void model(input int ma, input bit sa, input int ea,
                                input int mb, input bit sb, input int eb, input bit opv,
                                output int rm, output int re, output bit rs,
                                output bit uf, output int lat);
    int  bm, be, sm, se, sum, e, l;
    bit  bs, ss, sbe;
    sbe = sb ^ opv;
    if (ea > eb || (ea == eb && ma >= mb)) begin
      bm = ma; be = ea; bs = sa; sm = mb; se = eb; ss = sbe;
    end else begin
      bm = mb; be = eb; bs = sbe; sm = ma; se = ea; ss = sa;
    end
    sm  = (be - se >= MAN_W) ? 0 : (sm >> (be - se));
    sum = (bs != ss) ? bm - sm : bm + sm;
    e = be; l = 0; uf = 0; rs = bs;
    if (sum == 0) begin
      e = 0; rs = 0;
    end else if (sum >= (1 << MAN_W)) begin
      sum = sum / 2; e = e + 1;
    end else begin
      while (sum < (1 << (MAN_W - 1)) && e > 0) begin
        sum = sum * 2; e = e - 1; l = l + 1;
      end
      if (sum < (1 << (MAN_W - 1))) uf = 1;
    end
    rm = sum; re = e; lat = 4 + l;
  endfunction

  task automatic randomiseInputs();
    man_a = MAN_W'($urandom_range(0, 1023));
    man_b = MAN_W'($urandom_range(0, 1023));
    exp_a = EXP_W'($urandom_range(0, 31));
    exp_b = EXP_W'($urandom_range(0, 31));
    sgn_a = 1'($urandom_range(0, 1));
    sgn_b = 1'($urandom_range(0, 1));
    op    = 1'($urandom_range(0, 1));
  endtask

  task automatic applyStimulus(input string tag, input int ma, input bit sa, input int ea,
                               input int mb, input bit sb, input int eb, input bit opv,
                               input int hold);
    int rm, re, lat, cycles;
    bit rs, uf;
    model(ma, sa, ea, mb, sb, eb, opv, rm, re, rs, uf, lat);
    @(negedge clk);
    checkOutput({tag, " in_ready idle"}, 32'(in_ready), 32'd1);
    man_a = MAN_W'(ma); sgn_a = sa; exp_a = EXP_W'(ea);
    man_b = MAN_W'(mb); sgn_b = sb; exp_b = EXP_W'(eb);
    op = opv; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    randomiseInputs();
    cycles = 0;
    while (cycles < 40) begin
      @(negedge clk);
      cycles++;
      if (out_valid) break;
      randomiseInputs();
    end
    checkOutput({tag, " latency"}, 32'(cycles), 32'(lat));
    for (int i = 0; i <= hold; i++) begin
      checkOutput({tag, " res_man"}, 32'(res_man), 32'(rm));
      checkOutput({tag, " res_exp"}, 32'(res_exp), 32'(re));
      checkOutput({tag, " res_sgn"}, 32'(res_sgn), 32'(rs));
      checkOutput({tag, " underflow"}, 32'(underflow), 32'(uf));
      checkOutput({tag, " out_valid"}, 32'(out_valid), 32'd1);
      checkOutput({tag, " in_ready busy"}, 32'(in_ready), 32'd0);
      if (i < hold) begin
        in_valid = 1'b1;
        randomiseInputs();
        @(negedge clk);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checkOutput({tag, " out_valid drop"}, 32'(out_valid), 32'd0);
    checkOutput({tag, " busy drop"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int ma, mb;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    man_a = '0; man_b = '0; exp_a = '0; exp_b = '0; sgn_a = 0; sgn_b = 0; op = 0;
    repeat (2) @(negedge clk);
    checkOutput("reset out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset res_man", 32'(res_man), 32'd0);
    checkOutput("reset res_exp", 32'(res_exp), 32'd0);
    checkOutput("reset underflow", 32'(underflow), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("post-reset in_ready", 32'(in_ready), 32'd1);

    applyStimulus("add carry", 'h200, 0, 3, 'h200, 0, 3, 0, 0);
    applyStimulus("sub norm", 'h300, 0, 2, 'h200, 0, 2, 1, 0);
    applyStimulus("cancel", 'h200, 0, 5, 'h200, 0, 5, 1, 0);
    applyStimulus("swap sub", 'h200, 0, 1, 'h300, 0, 1, 1, 0);
    applyStimulus("large shift", 'h200, 0, 20, 'h3FF, 0, 5, 0, 0);
    applyStimulus("underflow", 'h201, 0, 0, 'h200, 0, 0, 1, 0);
    applyStimulus("backpressure", 'h2AB, 1, 7, 'h311, 0, 6, 0, 3);

    // Abandon an operation partway through its left-shift sequence.
    @(negedge clk);
    man_a = 10'h300; exp_a = 5'd9; sgn_a = 0;
    man_b = 10'h2FF; exp_b = 5'd9; sgn_b = 0; op = 1; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("mid-op busy", 32'(busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    checkOutput("async rst busy", 32'(busy), 32'd0);
    checkOutput("async rst out_valid", 32'(out_valid), 32'd0);
    checkOutput("async rst in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    repeat (12) begin
      @(negedge clk);
      checkOutput("after rst out_valid", 32'(out_valid), 32'd0);
    end
    applyStimulus("long norm", 'h300, 0, 9, 'h2FF, 0, 9, 1, 0);

    for (int n = 0; n < 40; n++) begin
      ma = ($urandom_range(0, 1) == 1) ? int'($urandom_range(512, 1023)) : int'($urandom_range(0, 1023));
      mb = ($urandom_range(0, 1) == 1) ? int'($urandom_range(512, 1023)) : int'($urandom_range(0, 1023));
      applyStimulus($sformatf("rand%0d", n), ma, 1'($urandom_range(0, 1)),
                    int'($urandom_range(0, 31)), mb, 1'($urandom_range(0, 1)),
                    int'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                    int'($urandom_range(0, 2)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
